axis_pkt_rx: RTL and testbench

AXI-Stream slave-side packet receiver. Accepts beats from any AXI-Stream master (tvalid/tready/tdata/tkeep/tlast/tid), stores them in a first-word-fall-through beat FIFO, and emits one descriptor per packet carrying byte length, routing ID and error flags. It is the consuming endpoint that downstream engines and multi-core schedulers use to drain a stream port.

---
 rtl/axis_pkt_rx.sv | 159 +++++++++++++++
 tb/tb_axis_pkt_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_rx.sv
// AXI-Stream packet receiver: FWFT beat FIFO plus one length/tid/error descriptor per packet.
// Optional AXIS_RX_STATS_EN adds stat_pkts/stat_errs counters.
module axis_pkt_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  input  logic [ID_WIDTH-1:0]     s_tid,
  input  logic                    rd_en,
  output logic                    rd_empty,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [DATA_WIDTH/8-1:0] rd_keep,
  output logic                    rd_last,
  output logic                    desc_valid,
  input  logic                    desc_ready,
  output logic [LEN_WIDTH-1:0]    desc_len,
  output logic [ID_WIDTH-1:0]     desc_tid,
  output logic [2:0]              desc_err
`ifdef AXIS_RX_STATS_EN
  ,
  output logic [31:0]             stat_pkts,
  output logic [31:0]             stat_errs
`endif
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RECV, DESC} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [KW-1:0]         mem_keep [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  live_q;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ID_WIDTH-1:0]   tid_q, tid_d;
  logic [2:0]            err_q, err_d;
  logic                  push, pop, keep_bad, ovf;
  logic [KW-1:0]         keep_inc;
  logic [LEN_WIDTH:0]    sum;

  function automatic logic [LEN_WIDTH:0] popcnt(input logic [KW-1:0] k);
    logic [LEN_WIDTH:0] n;
    n = '0;
    for (int i = 0; i < KW; i++) n = n + {{LEN_WIDTH{1'b0}}, k[i]};
    return n;
  endfunction

  assign push     = s_tvalid && s_tready;
  assign rd_empty = (cnt_q == '0);
  assign pop      = rd_en && !rd_empty;
  assign rd_data  = rd_empty ? '0 : mem_data[rd_ptr_q];
  assign rd_keep  = rd_empty ? '0 : mem_keep[rd_ptr_q];
  assign rd_last  = rd_empty ? 1'b0 : mem_last[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = s_tlast ? DESC : RECV;
      RECV:    if (push && s_tlast) state_d = DESC;
      DESC:    if (desc_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // live_q keeps s_tready low during reset and releases it one edge later
  always_comb begin
    s_tready   = live_q && (cnt_q != CW'(FIFO_DEPTH)) && (state_q != DESC);
    desc_valid = (state_q == DESC);
    desc_len   = desc_valid ? len_q : '0;
    desc_tid   = desc_valid ? tid_q : '0;
    desc_err   = desc_valid ? err_q : '0;
  end

  always_comb begin
    keep_inc = s_tkeep + 1'b1;
    keep_bad = s_tlast ? ((s_tkeep == '0) || ((s_tkeep & keep_inc) != '0))
                       : (s_tkeep != '1);
    sum      = ((state_q == IDLE) ? '0 : {1'b0, len_q}) + popcnt(s_tkeep);
    ovf      = sum[LEN_WIDTH];
    len_d    = len_q;
    tid_d    = tid_q;
    err_d    = err_q;
    if (push) begin
      len_d = ovf ? '1 : sum[LEN_WIDTH-1:0];
      if (state_q == IDLE) begin
        tid_d = s_tid;
        err_d = {ovf, keep_bad, 1'b0};
      end else begin
        err_d = err_q | {ovf, keep_bad, s_tid != tid_q};
      end
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      tid_q    <= '0;
      err_q    <= '0;
    end else begin
      live_q <= 1'b1;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      tid_q  <= tid_d;
      err_q  <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: reads are masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= s_tdata;
      mem_keep[wr_ptr_q] <= s_tkeep;
      mem_last[wr_ptr_q] <= s_tlast;
    end
  end

`ifdef AXIS_RX_STATS_EN
  logic [31:0] stat_pkts_q, stat_errs_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_pkts_q <= '0;
      stat_errs_q <= '0;
    end else if (state_q == DESC && desc_ready) begin
      stat_pkts_q <= stat_pkts_q + 32'd1;
      if (err_q != '0) stat_errs_q <= stat_errs_q + 32'd1;
    end
  end
  assign stat_pkts = stat_pkts_q;
  assign stat_errs = stat_errs_q;
`endif
endmodule

// File: tb/tb_axis_pkt_rx.sv
// Directed bench for axis_pkt_rx: cycle table for the basic packets, hand sequences for corners.
module tb_axis_pkt_rx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid, s_tready, s_tlast, rd_en, rd_empty, rd_last;
  logic        desc_valid, desc_ready;
  logic [31:0] s_tdata, rd_data;
  logic [3:0]  s_tkeep, rd_keep;
  logic [1:0]  s_tid, desc_tid;
  logic [15:0] desc_len;
  logic [2:0]  desc_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axis_pkt_rx dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid),
    .rd_en(rd_en), .rd_empty(rd_empty), .rd_data(rd_data),
    .rd_keep(rd_keep), .rd_last(rd_last),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_len(desc_len), .desc_tid(desc_tid), .desc_err(desc_err)
  );

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  tid;
    logic        dr;
    logic        re;
    logic        e_rdy;
    logic        e_empty;
    logic [31:0] e_rdata;
    logic        e_rlast;
    logic        e_dv;
    logic [15:0] e_len;
    logic [1:0]  e_tid;
    logic [2:0]  e_err;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic [31:0] data, input logic [3:0] keep,
                              input logic last, input logic [1:0] tid, input logic dr,
                              input logic re, input logic e_rdy, input logic e_empty,
                              input logic [31:0] e_rdata, input logic e_rlast, input logic e_dv,
                              input logic [15:0] e_len, input logic [1:0] e_tid,
                              input logic [2:0] e_err);
    vec_t v;
    v.vld = vld; v.data = data; v.keep = keep; v.last = last; v.tid = tid;
    v.dr = dr; v.re = re; v.e_rdy = e_rdy; v.e_empty = e_empty; v.e_rdata = e_rdata;
    v.e_rlast = e_rlast; v.e_dv = e_dv; v.e_len = e_len; v.e_tid = e_tid; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic [1:0] t);
    s_tvalid = vld; s_tdata = d; s_tkeep = k; s_tlast = l; s_tid = t;
  endtask

  vec_t tbl[18];

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; desc_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);

    // cycle table: expectations are the outputs just after the edge
    tbl[0]  = mk(1, 32'hA1, 4'hF, 0, 2, 1, 0,  1, 0, 32'hA1, 0,  0, 16'd0,  0, 3'b000);
    tbl[1]  = mk(1, 32'hA2, 4'hF, 0, 2, 1, 0,  1, 0, 32'hA1, 0,  0, 16'd0,  0, 3'b000);
    tbl[2]  = mk(1, 32'hA3, 4'h3, 1, 2, 1, 0,  0, 0, 32'hA1, 0,  1, 16'd10, 2, 3'b000);
    tbl[3]  = mk(0, 32'h0,  4'h0, 0, 0, 1, 0,  1, 0, 32'hA1, 0,  0, 16'd0,  0, 3'b000);
    tbl[4]  = mk(0, 32'h0,  4'h0, 0, 0, 1, 1,  1, 0, 32'hA2, 0,  0, 16'd0,  0, 3'b000);
    tbl[5]  = mk(0, 32'h0,  4'h0, 0, 0, 1, 1,  1, 0, 32'hA3, 1,  0, 16'd0,  0, 3'b000);
    tbl[6]  = mk(0, 32'h0,  4'h0, 0, 0, 1, 1,  1, 1, 32'h0,  0,  0, 16'd0,  0, 3'b000);
    tbl[7]  = mk(0, 32'h0,  4'h0, 0, 0, 1, 1,  1, 1, 32'h0,  0,  0, 16'd0,  0, 3'b000);
    tbl[8]  = mk(1, 32'hB1, 4'h7, 0, 0, 0, 0,  1, 0, 32'hB1, 0,  0, 16'd0,  0, 3'b000);
    tbl[9]  = mk(1, 32'hB2, 4'h5, 1, 0, 0, 0,  0, 0, 32'hB1, 0,  1, 16'd5,  0, 3'b010);
    tbl[10] = mk(0, 32'h0,  4'h0, 0, 0, 1, 0,  1, 0, 32'hB1, 0,  0, 16'd0,  0, 3'b000);
    tbl[11] = mk(0, 32'h0,  4'h0, 0, 0, 0, 1,  1, 0, 32'hB2, 1,  0, 16'd0,  0, 3'b000);
    tbl[12] = mk(0, 32'h0,  4'h0, 0, 0, 0, 1,  1, 1, 32'h0,  0,  0, 16'd0,  0, 3'b000);
    tbl[13] = mk(1, 32'hC1, 4'hF, 0, 1, 0, 0,  1, 0, 32'hC1, 0,  0, 16'd0,  0, 3'b000);
    tbl[14] = mk(1, 32'hC2, 4'hF, 1, 3, 0, 0,  0, 0, 32'hC1, 0,  1, 16'd8,  1, 3'b001);
    tbl[15] = mk(0, 32'h0,  4'h0, 0, 0, 1, 0,  1, 0, 32'hC1, 0,  0, 16'd0,  0, 3'b000);
    tbl[16] = mk(0, 32'h0,  4'h0, 0, 0, 0, 1,  1, 0, 32'hC2, 1,  0, 16'd0,  0, 3'b000);
    tbl[17] = mk(0, 32'h0,  4'h0, 0, 0, 0, 1,  1, 1, 32'h0,  0,  0, 16'd0,  0, 3'b000);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst tready", s_tready, 0);
    chk("rst empty", rd_empty, 1);
    chk("rst rd_data", rd_data, 0);
    chk("rst rd_keep", rd_keep, 0);
    chk("rst rd_last", rd_last, 0);
    chk("rst desc_valid", desc_valid, 0);
    chk("rst desc_len", desc_len, 0);
    chk("rst desc_tid", desc_tid, 0);
    chk("rst desc_err", desc_err, 0);
    rst_n = 1'b1;
    #1 chk("tready before first edge", s_tready, 0);
    tick();
    chk("tready after release", s_tready, 1);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].vld, tbl[i].data, tbl[i].keep, tbl[i].last, tbl[i].tid);
      desc_ready = tbl[i].dr;
      rd_en = tbl[i].re;
      tick();
      chk($sformatf("v%0d tready", i), s_tready, tbl[i].e_rdy);
      chk($sformatf("v%0d empty", i), rd_empty, tbl[i].e_empty);
      chk($sformatf("v%0d rd_data", i), rd_data, tbl[i].e_rdata);
      chk($sformatf("v%0d rd_last", i), rd_last, tbl[i].e_rlast);
      chk($sformatf("v%0d desc_valid", i), desc_valid, tbl[i].e_dv);
      chk($sformatf("v%0d desc_len", i), desc_len, tbl[i].e_len);
      chk($sformatf("v%0d desc_tid", i), desc_tid, tbl[i].e_tid);
      chk($sformatf("v%0d desc_err", i), desc_err, tbl[i].e_err);
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    rd_en = 1'b0;

    // fill: 8 single-beat packets with no pops
    desc_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'hD0 + k, 4'hF, 1'b1, 2'd0);
      tick();
      chk($sformatf("fill%0d desc_len", k), desc_len, 4);
      drive(1'b0, '0, '0, 1'b0, '0);
      tick();
    end
    chk("full tready", s_tready, 0);
    rd_en = 1'b1;
    #1 chk("pop at full same cycle tready", s_tready, 0);
    tick();
    rd_en = 1'b0;
    chk("after pop tready", s_tready, 1);
    rd_en = 1'b1;
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("fill head%0d", k), rd_data, 32'hD0 + k);
      tick();
    end
    rd_en = 1'b0;
    chk("fill drained", rd_empty, 1);

    // descriptor stall
    desc_ready = 1'b0;
    drive(1'b1, 32'hE1, 4'hF, 1'b0, 2'd1);
    tick();
    drive(1'b1, 32'hE2, 4'h1, 1'b1, 2'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d tready", c), s_tready, 0);
      chk($sformatf("stall%0d valid", c), desc_valid, 1);
      chk($sformatf("stall%0d len", c), desc_len, 5);
      chk($sformatf("stall%0d tid", c), desc_tid, 1);
      chk($sformatf("stall%0d err", c), desc_err, 0);
      tick();
    end
    desc_ready = 1'b1;
    tick();
    chk("stall release valid", desc_valid, 0);
    chk("stall release tready", s_tready, 1);
    rd_en = 1'b1;
    tick();
    chk("stall head2", rd_data, 32'hE2);
    chk("stall head2 keep", rd_keep, 4'h1);
    tick();
    rd_en = 1'b0;
    chk("stall drained", rd_empty, 1);

    // reset mid-packet
    drive(1'b1, 32'hF1, 4'hF, 1'b0, 2'd2);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    chk("pre-reset empty", rd_empty, 0);
    rst_n = 1'b0;
    tick();
    chk("midrst empty", rd_empty, 1);
    chk("midrst desc_valid", desc_valid, 0);
    chk("midrst tready", s_tready, 0);
    rst_n = 1'b1;
    tick();
    chk("midrst tready back", s_tready, 1);
    desc_ready = 1'b0;
    drive(1'b1, 32'h55, 4'h3, 1'b1, 2'd0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    chk("post-rst len", desc_len, 2);
    chk("post-rst err", desc_err, 0);
    chk("post-rst head", rd_data, 32'h55);
    desc_ready = 1'b1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post-rst drained", rd_empty, 1);

    // length overflow with concurrent push/pop
    desc_ready = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 16384; i++) begin
      drive(1'b1, i, 4'hF, i == 16383, 2'd0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    chk("ovf valid", desc_valid, 1);
    chk("ovf len", desc_len, 16'hFFFF);
    chk("ovf err", desc_err, 3'b100);
    chk("ovf head", rd_data, 16383);
    chk("ovf head last", rd_last, 1);
    desc_ready = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("ovf drained", rd_empty, 1);
    chk("ovf idle tready", s_tready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
